ifft8_serial: RTL



---
 rtl/ifft8_pkg.sv | 65 ++++++
 rtl/ifft8_bf.sv | 76 +++++++
 rtl/ifft8_serial.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ifft8_pkg.sv
// -----------------------------------------------------------------------------
// ifft8_pkg -- shared definitions for the serial 8-point inverse FFT.
//
// Contents:
//   IFFT8_DATA_W / IFFT8_FRAC_W : default sample width and fraction bits (Q8.8)
//   state_t                     : control states LOAD -> COMP -> UNLOAD
//   TW_RE / TW_IM               : conjugate twiddles e^{+j*2*pi*k/8}, k = 0..3,
//                                 quantised so that 1.0 = 256
//   bf_addr_t / bf_addr()       : register-file pair addresses and twiddle index
//                                 for butterfly number 0..11 (decimation in time)
//   bitrev3()                   : 3-bit bit reversal for the load address
// -----------------------------------------------------------------------------
package ifft8_pkg;

  localparam int IFFT8_DATA_W = 16;
  localparam int IFFT8_FRAC_W = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMP   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  // Inverse transform uses the conjugate twiddle W^-k = cos + j*sin.
  localparam int TW_RE [4] = '{256, 181,   0, -181};
  localparam int TW_IM [4] = '{  0, 181, 256,  181};

  typedef struct packed {
    logic [2:0] top;  // x1 / y1 address
    logic [2:0] bot;  // x2 / y2 address
    logic [1:0] tw;   // twiddle index applied to x2
  } bf_addr_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Butterfly count c: stage = c[3:2] (span 1, 2, 4), butterfly j = c[1:0].
  // Within a stage the j-th butterfly sits in group j>>s at offset j&(span-1);
  // the twiddle step shrinks as the span grows (4, 2, 1 eighth-turns).
  function automatic bf_addr_t bf_addr(input logic [3:0] cnt);
    bf_addr_t a;
    a = '0;
    case (cnt[3:2])
      2'd0: begin
        a.top = {cnt[1:0], 1'b0};
        a.bot = {cnt[1:0], 1'b1};
        a.tw  = 2'd0;
      end
      2'd1: begin
        a.top = {cnt[1], 1'b0, cnt[0]};
        a.bot = {cnt[1], 1'b1, cnt[0]};
        a.tw  = {cnt[0], 1'b0};
      end
      2'd2: begin
        a.top = {1'b0, cnt[1:0]};
        a.bot = {1'b1, cnt[1:0]};
        a.tw  = cnt[1:0];
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ifft8_bf.sv
// -----------------------------------------------------------------------------
// ifft8_bf -- combinational radix-2 DIT butterfly with per-stage 1/2 scaling.
//
//   p  = (x2 * w) >>> FRAC_W          (complex product, full precision first)
//   y1 = (x1 + p) >>> 1
//   y2 = (x1 - p) >>> 1
//
// Default build truncates toward -inf on every shift. With the macro
// IFFT8_ROUND_EN defined, each shift first adds half an output LSB
// (round half up). Results are truncated back to DATA_W bits; the halving at
// every stage keeps in-range data from wrapping, so there is no saturation.
//
// Ports:
//   i_x1_re/i_x1_im : upper input      i_x2_re/i_x2_im : lower input
//   i_w_re/i_w_im   : twiddle (Q FRAC_W)
//   o_y1_re/o_y1_im : sum output       o_y2_re/o_y2_im : difference output
// -----------------------------------------------------------------------------
module ifft8_bf
  import ifft8_pkg::*;
#(
  parameter int DATA_W = IFFT8_DATA_W,
  parameter int FRAC_W = IFFT8_FRAC_W
) (
  input  logic signed [DATA_W-1:0] i_x1_re,
  input  logic signed [DATA_W-1:0] i_x1_im,
  input  logic signed [DATA_W-1:0] i_x2_re,
  input  logic signed [DATA_W-1:0] i_x2_im,
  input  logic signed [DATA_W-1:0] i_w_re,
  input  logic signed [DATA_W-1:0] i_w_im,
  output logic signed [DATA_W-1:0] o_y1_re,
  output logic signed [DATA_W-1:0] o_y1_im,
  output logic signed [DATA_W-1:0] o_y2_re,
  output logic signed [DATA_W-1:0] o_y2_im
);

  // Internal width holds the full complex product plus the add/sub growth,
  // so no intermediate can wrap before the final truncation.
  localparam int PW = 2 * DATA_W + 2;

`ifdef IFFT8_ROUND_EN
  localparam logic signed [PW-1:0] P_RND = PW'(2 ** (FRAC_W - 1));
  localparam logic signed [PW-1:0] H_RND = PW'(1);
`else
  localparam logic signed [PW-1:0] P_RND = '0;
  localparam logic signed [PW-1:0] H_RND = '0;
`endif

  logic signed [PW-1:0] w_x1_re, w_x1_im;
  logic signed [PW-1:0] w_x2_re, w_x2_im;
  logic signed [PW-1:0] w_w_re,  w_w_im;
  logic signed [PW-1:0] w_p_re,  w_p_im;
  logic signed [PW-1:0] w_s1_re, w_s1_im;
  logic signed [PW-1:0] w_s2_re, w_s2_im;

  // Signed size casts sign-extend into the wide datapath.
  assign w_x1_re = PW'(i_x1_re);
  assign w_x1_im = PW'(i_x1_im);
  assign w_x2_re = PW'(i_x2_re);
  assign w_x2_im = PW'(i_x2_im);
  assign w_w_re  = PW'(i_w_re);
  assign w_w_im  = PW'(i_w_im);

  assign w_p_re = (w_x2_re * w_w_re - w_x2_im * w_w_im + P_RND) >>> FRAC_W;
  assign w_p_im = (w_x2_re * w_w_im + w_x2_im * w_w_re + P_RND) >>> FRAC_W;

  assign w_s1_re = (w_x1_re + w_p_re + H_RND) >>> 1;
  assign w_s1_im = (w_x1_im + w_p_im + H_RND) >>> 1;
  assign w_s2_re = (w_x1_re - w_p_re + H_RND) >>> 1;
  assign w_s2_im = (w_x1_im - w_p_im + H_RND) >>> 1;

  assign o_y1_re = DATA_W'(w_s1_re);
  assign o_y1_im = DATA_W'(w_s1_im);
  assign o_y2_re = DATA_W'(w_s2_re);
  assign o_y2_im = DATA_W'(w_s2_im);

endmodule

// File: rtl/ifft8_serial.sv
// -----------------------------------------------------------------------------
// ifft8_serial -- streaming 8-point inverse FFT (radix-2 DIT, in place).
//
// Frequency bins arrive one per beat (bin k on the k-th accepted beat) and are
// stored bit-reversed. Twelve butterflies (3 stages x 4) then run one per
// clock on a single shared ifft8_bf, reading and writing the register file on
// the same edge. Each stage halves, so the result carries the 1/8 inverse
// normalisation. Time samples leave one per beat, sample n on the n-th beat.
// Frames do not overlap: LOAD -> COMP -> UNLOAD -> LOAD.
//
// Optional feature: define IFFT8_ROUND_EN for round-half-up on every shift
// inside the butterfly; timing is the same either way.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   / in_ready  : input handshake (ready only in LOAD)
//   in_real    / in_imag   : complex bin, DATA_W two's complement
//   out_valid  / out_ready : output handshake (valid only in UNLOAD)
//   out_real   / out_imag  : complex time sample, zero outside UNLOAD
//   out_last   : high together with sample 7
//   busy       : high in COMP or UNLOAD
// -----------------------------------------------------------------------------
module ifft8_serial
  import ifft8_pkg::*;
#(
  parameter int DATA_W = IFFT8_DATA_W,
  parameter int FRAC_W = IFFT8_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [3:0] BF_LAST = 4'd11;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0] r_in_cnt;
  logic [3:0] r_bf_cnt;
  logic [2:0] r_out_cnt;

  logic signed [DATA_W-1:0] r_mem_re [8];
  logic signed [DATA_W-1:0] r_mem_im [8];

  bf_addr_t                 w_addr;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic signed [DATA_W-1:0] w_x1_re, w_x1_im, w_x2_re, w_x2_im;
  logic signed [DATA_W-1:0] w_w_re,  w_w_im;
  logic signed [DATA_W-1:0] w_y1_re, w_y1_im, w_y2_re, w_y2_im;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would make results depend on order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    out_real    = '0;
    out_imag    = '0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_in_cnt == 3'd7)) begin
          w_state_nxt = COMP;
        end
      end
      COMP: begin
        busy = 1'b1;
        if (r_bf_cnt == BF_LAST) begin
          w_state_nxt = UNLOAD;
        end
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (r_out_cnt == 3'd7);
        out_real  = r_mem_re[r_out_cnt];
        out_imag  = r_mem_im[r_out_cnt];
        if (out_ready && (r_out_cnt == 3'd7)) begin
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Shared butterfly: operands straight from the register file
  // ---------------------------------------------------------------------------
  assign w_addr  = bf_addr(r_bf_cnt);
  assign w_x1_re = r_mem_re[w_addr.top];
  assign w_x1_im = r_mem_im[w_addr.top];
  assign w_x2_re = r_mem_re[w_addr.bot];
  assign w_x2_im = r_mem_im[w_addr.bot];
  assign w_w_re  = DATA_W'(TW_RE[w_addr.tw]);
  assign w_w_im  = DATA_W'(TW_IM[w_addr.tw]);

  ifft8_bf #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_bf (
    .i_x1_re (w_x1_re),
    .i_x1_im (w_x1_im),
    .i_x2_re (w_x2_re),
    .i_x2_im (w_x2_im),
    .i_w_re  (w_w_re),
    .i_w_im  (w_w_im),
    .o_y1_re (w_y1_re),
    .o_y1_im (w_y1_im),
    .o_y2_re (w_y2_re),
    .o_y2_im (w_y2_im)
  );

  // ---------------------------------------------------------------------------
  // Register file and counters
  // ---------------------------------------------------------------------------
  // NOTE: the 8x2 register file is cleared by reset so a reset mid-frame
  // leaves no stale samples; this is why it is flops, not an inferred RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_cnt  <= '0;
      r_bf_cnt  <= '0;
      r_out_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        r_mem_re[i] <= '0;
        r_mem_im[i] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          r_bf_cnt <= '0;
          if (w_in_fire) begin
            // Bit-reversed store lets the DIT stages run in natural order.
            r_mem_re[bitrev3(r_in_cnt)] <= in_real;
            r_mem_im[bitrev3(r_in_cnt)] <= in_imag;
            r_in_cnt                    <= r_in_cnt + 3'd1;
          end
        end
        COMP: begin
          // Both results land on the edge that consumed the operands.
          r_mem_re[w_addr.top] <= w_y1_re;
          r_mem_im[w_addr.top] <= w_y1_im;
          r_mem_re[w_addr.bot] <= w_y2_re;
          r_mem_im[w_addr.bot] <= w_y2_im;
          r_bf_cnt             <= (r_bf_cnt == BF_LAST) ? 4'd0 : r_bf_cnt + 4'd1;
        end
        UNLOAD: begin
          // 3-bit counter wraps to 0 on the last sample, ready for next frame.
          if (w_out_fire) begin
            r_out_cnt <= r_out_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
